// File: rtl/data_mem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-ported data memory.
// Each transaction walks IDLE -> ACCESS -> RESP; ties go to a round-robin pointer.
module data_mem_arbiter #(
  parameter int DEPTH = 32,
  parameter int SHIFT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ReqA,
  input  logic        ReqB,
  input  logic        WeA,
  input  logic        WeB,
  input  logic [31:0] AddrA,
  input  logic [31:0] AddrB,
  input  logic [31:0] WDataA,
  input  logic [31:0] WDataB,
  output logic        AckA,
  output logic        AckB,
  output logic        ErrA,
  output logic        ErrB,
  output logic [31:0] RDataA,
  output logic [31:0] RDataB,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemRData,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds Req/We/Addr/WData stable from assertion until
  // the single cycle its Ack is 1; Ack is a one-cycle pulse with Err/RData valid.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        grant_b;
  logic [31:0] word_idx;
  logic        oor;

  assign dbg_state = state_q;
  assign word_idx  = addr_q >> SHIFT;
  assign oor       = (word_idx >= 32'(DEPTH));

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    grant_b  = 1'b0;
    AckA     = 1'b0;
    AckB     = 1'b0;
    ErrA     = 1'b0;
    ErrB     = 1'b0;
    RDataA   = 32'd0;
    RDataB   = 32'd0;
    MemAddr  = 32'd0;
    MemWData = 32'd0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ReqA || ReqB) begin
          grant_b = ReqB && (!ReqA || prio_q);
          win_d   = grant_b;
          prio_d  = !grant_b;
          we_d    = grant_b ? WeB : WeA;
          addr_d  = grant_b ? AddrB : AddrA;
          wdata_d = grant_b ? WDataB : WDataA;
          err_d   = 1'b0;
          rdata_d = 32'd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Strobes are gated by reset_n so a reset landing here never commits a write.
        if (!oor && reset_n) begin
          MemAddr  = addr_q;
          MemWData = wdata_q;
          MemWrite = we_q;
          MemRead  = !we_q;
        end
        err_d   = oor;
        rdata_d = (!we_q && !oor) ? MemRData : 32'd0;
        state_d = RESP;
      end
      RESP: begin
        if (reset_n) begin
          if (win_q) begin
            AckB   = 1'b1;
            ErrB   = err_q;
            RDataB = rdata_q;
          end else begin
            AckA   = 1'b1;
            ErrA   = err_q;
            RDataA = rdata_q;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 32-word behavioural memory.
// Inputs change and outputs are sampled on the falling edge.
module tb_data_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        ReqA, ReqB, WeA, WeB;
  logic [31:0] AddrA, AddrB, WDataA, WDataB;
  logic        AckA, AckB, ErrA, ErrB;
  logic [31:0] RDataA, RDataB;
  logic [31:0] MemAddr, MemWData, MemRData;
  logic        MemWrite, MemRead;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:31];
  logic [7:0]  exp_q [$];

  data_mem_arbiter #(.DEPTH(32), .SHIFT(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .ReqA(ReqA), .ReqB(ReqB), .WeA(WeA), .WeB(WeB),
    .AddrA(AddrA), .AddrB(AddrB), .WDataA(WDataA), .WDataB(WDataB),
    .AckA(AckA), .AckB(AckB), .ErrA(ErrA), .ErrB(ErrB),
    .RDataA(RDataA), .RDataB(RDataB),
    .MemAddr(MemAddr), .MemWData(MemWData),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .MemRData(MemRData), .dbg_state(dbg_state)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign MemRData = mem[MemAddr[7:3]];
  always @(posedge clk) if (MemWrite) mem[MemAddr[7:3]] <= MemWData;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ReqA = 0; ReqB = 0; WeA = 0; WeB = 0;
    AddrA = 0; AddrB = 0; WDataA = 0; WDataB = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ack"}, {30'd0, AckA, AckB}, 32'd0);
    check_eq({tag, "_err"}, {30'd0, ErrA, ErrB}, 32'd0);
    check_eq({tag, "_rd"}, RDataA | RDataB, 32'd0);
    check_eq({tag, "_strobe"}, {30'd0, MemWrite, MemRead}, 32'd0);
    check_eq({tag, "_maddr"}, MemAddr | MemWData, 32'd0);
  endtask

  task automatic drive_a(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    ReqA = 1; WeA = we; AddrA = addr; WDataA = wd;
  endtask

  task automatic drive_b(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    ReqB = 1; WeB = we; AddrB = addr; WDataB = wd;
  endtask

  initial begin
    int ack_b_seen;
    int strobe_seen;
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    idle_inputs();
    reset_n = 0;

    // reset state
    tick(); tick();
    check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
    check_all_zero("rst");
    reset_n = 1;
    tick();

    // single read from word 5
    mem[5] = 32'hDEAD_BEEF;
    drive_a(0, 32'd40, 32'd0);
    tick();
    check_eq("rd_memread", {31'd0, MemRead}, 32'd1);
    check_eq("rd_memaddr", MemAddr, 32'd40);
    check_eq("rd_nowrite", {31'd0, MemWrite}, 32'd0);
    check_eq("rd_early_ack", {31'd0, AckA}, 32'd0);
    tick();
    check_eq("rd_acka", {31'd0, AckA}, 32'd1);
    check_eq("rd_rdata", RDataA, 32'hDEAD_BEEF);
    check_eq("rd_erra", {31'd0, ErrA}, 32'd0);
    check_eq("rd_loser", {30'd0, AckB, ErrB} | {31'd0, |RDataB}, 32'd0);
    idle_inputs();
    tick();
    check_all_zero("rd_after");

    // port B write then read at byte address 8
    drive_b(1, 32'd8, 32'h1234_5678);
    tick();
    check_eq("wr_memwrite", {31'd0, MemWrite}, 32'd1);
    check_eq("wr_wdata", MemWData, 32'h1234_5678);
    check_eq("wr_memaddr", MemAddr, 32'd8);
    tick();
    check_eq("wr_pulse_end", {31'd0, MemWrite}, 32'd0);
    check_eq("wr_ackb", {31'd0, AckB}, 32'd1);
    check_eq("wr_rdata_zero", RDataB, 32'd0);
    check_eq("wr_mem", mem[1], 32'h1234_5678);
    WeB = 0;
    tick();
    check_eq("wr_idle_nowrite", {31'd0, MemWrite}, 32'd0);
    tick();
    check_eq("rb_memread", {31'd0, MemRead}, 32'd1);
    tick();
    check_eq("rb_ackb", {31'd0, AckB}, 32'd1);
    check_eq("rb_rdata", RDataB, 32'h1234_5678);
    idle_inputs();
    tick();

    // contention from reset: A at 2, 8; B at 5, 11
    mem[0] = 32'hAAAA_0000;
    mem[2] = 32'hBBBB_0002;
    reset_n = 0;
    drive_a(0, 32'd0, 32'd0);
    drive_b(0, 32'd16, 32'd0);
    tick(); tick();
    check_eq("cont_rst_idle", {30'd0, dbg_state}, 32'd0);
    exp_q.push_back({1'b0, 7'd2});
    exp_q.push_back({1'b1, 7'd5});
    exp_q.push_back({1'b0, 7'd8});
    exp_q.push_back({1'b1, 7'd11});
    reset_n = 1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (AckA || AckB) begin
        if (exp_q.size() == 0) begin
          check_eq("cont_extra_ack", {24'd0, AckB, 7'(c)}, 32'hFFFF_FFFF);
        end else begin
          check_eq("cont_ack", {24'd0, AckB, 7'(c)}, {24'd0, exp_q.pop_front()});
          check_eq("cont_rdata", AckB ? RDataB : RDataA, AckB ? 32'hBBBB_0002 : 32'hAAAA_0000);
        end
      end
    end
    check_eq("cont_pending", exp_q.size(), 32'd0);
    idle_inputs();
    tick(); tick();

    // out of range (word 32) and boundary (word 31)
    drive_a(0, 32'd256, 32'd0);
    tick();
    check_eq("oor_strobe", {30'd0, MemWrite, MemRead}, 32'd0);
    tick();
    check_eq("oor_acka", {31'd0, AckA}, 32'd1);
    check_eq("oor_erra", {31'd0, ErrA}, 32'd1);
    check_eq("oor_rdata", RDataA, 32'd0);
    idle_inputs();
    tick();
    mem[31] = 32'h3131_3131;
    drive_a(0, 32'd255, 32'd0);
    tick();
    check_eq("edge_memread", {31'd0, MemRead}, 32'd1);
    tick();
    check_eq("edge_erra", {31'd0, ErrA}, 32'd0);
    check_eq("edge_rdata", RDataA, 32'h3131_3131);
    idle_inputs();
    tick();

    // reset during ACCESS of a write (Prio is 1 here)
    mem[3] = 32'h1111_1111;
    drive_a(1, 32'd24, 32'hCAFE_F00D);
    tick();
    reset_n = 0;
    #1;
    check_eq("rstmid_nowrite", {31'd0, MemWrite}, 32'd0);
    idle_inputs();
    tick();
    check_all_zero("rstmid_after");
    check_eq("rstmid_mem", mem[3], 32'h1111_1111);
    tick();
    check_all_zero("rstmid_noack");
    reset_n = 1;
    drive_a(0, 32'd0, 32'd0);
    drive_b(0, 32'd16, 32'd0);
    tick(); tick();
    check_eq("rstmid_prio_a", {30'd0, AckA, AckB}, 32'd2);
    idle_inputs();
    tick();

    // dropped B request while A is served
    drive_a(0, 32'd0, 32'd0);
    tick();
    drive_b(0, 32'd16, 32'd0);
    tick();
    check_eq("drop_acka", {31'd0, AckA}, 32'd1);
    check_eq("drop_rdata", RDataA, 32'hAAAA_0000);
    idle_inputs();
    ack_b_seen = 0;
    strobe_seen = 0;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (AckB) ack_b_seen++;
      if (MemRead || MemWrite) strobe_seen++;
    end
    check_eq("drop_no_ackb", ack_b_seen, 32'd0);
    check_eq("drop_no_access", strobe_seen, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: DEPTH, 32, number of words in the shared data memory.
REQ-002 Parameter: SHIFT, 3, right-shift applied to a byte address to form the word index.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset_n  input  1  reset, synchronous, active-low.
REQ-005 Port: ReqA / ReqB  input  1  transaction request from port A (CPU) / port B (DMA).
REQ-006 Port: WeA / WeB  input  1  1 = write, 0 = read.
REQ-007 Port: AddrA / AddrB  input  32  byte address.
REQ-008 Port: WDataA / WDataB  input  32  write data.
REQ-009 Port: AckA / AckB  output  1  one-cycle completion pulse.
REQ-010 Port: ErrA / ErrB  output  1  valid with Ack; 1 = address out of range.
REQ-011 Port: RDataA / RDataB  output  32  read data; valid only while the matching Ack is 1.
REQ-012 Port: MemAddr  output  32  address to the memory (byte address, unmodified).
REQ-013 Port: MemWData  output  32  write data to the memory.
REQ-014 Port: MemWrite / MemRead  output  1  memory strobes.
REQ-015 Port: MemRData  input  32  combinational read data from the memory.

Function
REQ-016 A requester SHALL hold Req, We, Addr and WData stable from assertion until the cycle its Ack is 1; the arbiter SHALL NOT check this.
REQ-017 FSM states: IDLE, ACCESS, RESP; a transaction SHALL take exactly IDLE->ACCESS->RESP->IDLE.
REQ-018 IDLE: if any Req is 1, the arbiter SHALL latch the winner, its We, Addr and WData into internal registers, and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-019 Winner: if only one Req is 1, that port wins; if both are 1, the port named by the priority pointer Prio (0 = A, 1 = B) wins.
REQ-020 After each grant, Prio SHALL point to the port that did not win; Prio SHALL be unchanged when no grant occurs.
REQ-021 Range check: a latched address is out of range when (Addr >> SHIFT) >= DEPTH.
REQ-022 ACCESS, in range: MemAddr/MemWData SHALL equal the latched values; MemWrite = We; MemRead = !We; MemRData SHALL be captured into a response register at the end of the cycle on a read.
REQ-023 ACCESS, out of range: MemWrite and MemRead SHALL be 0, and the error flag SHALL be latched.
REQ-024 RESP: the winner's Ack SHALL be 1 for exactly this cycle, with its Err and RData driven from registers; RData SHALL be 0 on writes and errors.
REQ-025 The losing port's Ack, Err and RData SHALL be 0 at all times it is not being served.
REQ-026 Outside ACCESS, MemWrite and MemRead SHALL be 0; MemAddr and MemWData SHALL be 0.
REQ-027 Requests arriving during ACCESS or RESP SHALL wait; they are considered at the next IDLE.
REQ-028 Back-to-back: with both Req held, grants SHALL alternate A, B, A, B…; each port SHALL be served at most 6 cycles after the other's Ack.
REQ-029 Latency: from Req sampled in IDLE to Ack SHALL be exactly 2 cycles; throughput SHALL be one transaction per 3 cycles.
REQ-030 A Req that drops before its grant SHALL be ignored; a Req that drops after its grant SHALL NOT abort the transaction.

Reset
REQ-031 While reset_n is 0 at a rising edge, the arbiter SHALL enter IDLE, set Prio = 0, and clear all latched registers.
REQ-032 During and after reset, all outputs SHALL be 0 until the next grant.
REQ-033 Reset asserted in ACCESS or RESP SHALL abandon the transaction: no Ack, and no MemWrite in the cycle after the reset edge.

Verification
REQ-034 Single read: preload word 5 = 0xDEADBEEF; ReqA=1, WeA=0, AddrA=40 -> MemRead=1 with MemAddr=40 at cycle +1; AckA=1, RDataA=0xDEADBEEF, ErrA=0 at cycle +2.
REQ-035 Write-then-read: port B writes 0x12345678 to AddrB=8, then reads AddrB=8 -> MemWrite pulse of exactly one cycle; the read returns 0x12345678.
REQ-036 Contention: ReqA and ReqB both 1 from reset, all reads -> AckA at cycles 2, 8; AckB at cycles 5, 11 (alternating order).
REQ-037 Out of range: ReqA read with AddrA=256 -> no MemRead/MemWrite; AckA=1, ErrA=1, RDataA=0.
REQ-038 Reset mid-transaction: write granted, reset_n=0 during ACCESS -> no Ack; memory word unchanged if reset precedes the ACCESS edge; next transaction after reset succeeds with Prio=0.
REQ-039 Dropped request: ReqB pulsed for one cycle while A is being served -> B is never acked; A's transaction completes normally.
